// File: rtl/channel_pkg.sv
// Shared definitions for the channel selection controller: states, result codes,
// status bit positions and command codes.
package channel_pkg;

  typedef enum logic [3:0] {
    IDLE, SEL, DROP_ADR, CMD, CMD_DROP, ISTAT,
    DATA, DATA_ACK, STOP, FSTAT, SVC_ACK, FINISH
  } state_t;

  localparam logic [2:0] RES_OK         = 3'd0;
  localparam logic [2:0] RES_NO_DEVICE  = 3'd1;
  localparam logic [2:0] RES_SHORT_BUSY = 3'd2;
  localparam logic [2:0] RES_BAD_ADDR   = 3'd3;
  localparam logic [2:0] RES_TIMEOUT    = 3'd4;
  localparam logic [2:0] RES_PARITY     = 3'd5;

  localparam int ST_BUSY = 4;
  localparam int ST_CE   = 3;
  localparam int ST_DE   = 2;
  localparam int ST_UC   = 1;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_NOP   = 8'h03;

  function automatic logic parity_ok(input logic [7:0] b, input logic p);
    return p == ~^b;
  endfunction

  // Initial status that terminates the operation without a data phase.
  function automatic logic status_ends(input logic [7:0] s);
    return s[ST_BUSY] | s[ST_UC] | (s[ST_CE] & s[ST_DE]);
  endfunction

endpackage

// File: rtl/chan_timer.sv
// Per-state watchdog: reloads to TIMEOUT on load and counts down to an expiry flag.
module chan_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               count <= CW'(TIMEOUT);
    else if (load)           count <= CW'(TIMEOUT);
    else if (count != '0)    count <= count - CW'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/channel_sel.sv
// Channel-side selection sequencer: selects a control unit, issues a command,
// moves data bytes under service handshakes and collects ending status.
module channel_sel
  import channel_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  dev_addr,
  input  logic [7:0]  command,
  input  logic [15:0] byte_count,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic [7:0]  status,
  output logic [2:0]  result,
  output logic [15:0] residual,
  output logic [7:0]  bus_out,
  output logic        bus_out_parity,
  input  logic [7:0]  bus_in,
  input  logic        bus_in_parity,
  output logic        operational_out,
  output logic        hold_out,
  output logic        select_out,
  output logic        address_out,
  output logic        command_out,
  output logic        service_out,
  output logic        suppress_out,
  input  logic        operational_in,
  input  logic        select_in,
  input  logic        address_in,
  input  logic        status_in,
  input  logic        service_in,
  input  logic        request_in
);

  state_t      state, state_nx;
  logic        phase, phase_nx, fin, fin_nx, write_op, write_nx, perr, perr_nx;
  logic        adr_nx, cmdt_nx, svc_nx, hold_nx, sel_nx, txr_nx, rxv_nx;
  logic [7:0]  addr_q, addr_nx, cmd_q, cmd_nx, bus_reg, bus_nx, rxd_nx, status_nx;
  logic [2:0]  result_nx;
  logic [15:0] resid_nx;
  logic        expired, bad_par;
  logic        unused_request;

  assign unused_request = request_in;

  chan_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (state_nx != state),
    .expired (expired)
  );

  assign bad_par         = !parity_ok(bus_in, bus_in_parity);
  assign bus_out         = (address_out | command_out | service_out) ? bus_reg : 8'h00;
  assign bus_out_parity  = ~^bus_out;
  assign operational_out = ~reset;
  assign suppress_out    = 1'b0;
  assign busy            = (state != IDLE) && (state != FINISH);
  assign done            = (state == FINISH);

  always_comb begin
    state_nx  = state;    phase_nx = phase;     fin_nx   = fin;      write_nx = write_op;
    perr_nx   = perr;     addr_nx  = addr_q;    cmd_nx   = cmd_q;    bus_nx   = bus_reg;
    adr_nx    = address_out; cmdt_nx = command_out; svc_nx = service_out;
    hold_nx   = hold_out; sel_nx   = select_out;
    txr_nx    = 1'b0;     rxv_nx   = 1'b0;      rxd_nx   = rx_data;
    status_nx = status;   result_nx = result;   resid_nx = residual;
    unique case (state)
      IDLE: if (start) begin
        addr_nx  = dev_addr;   cmd_nx  = command;  resid_nx = byte_count;
        result_nx = RES_OK;    perr_nx = 1'b0;     fin_nx   = 1'b0;
        write_nx = (command == CMD_WRITE);
        bus_nx   = dev_addr;   adr_nx  = 1'b1;     phase_nx = 1'b0;
        state_nx = SEL;
      end
      SEL: begin
        if (!phase) begin
          hold_nx = 1'b1; sel_nx = 1'b1; phase_nx = 1'b1;
        end else if (operational_in) begin
          adr_nx = 1'b0; sel_nx = 1'b0; hold_nx = 1'b0; state_nx = DROP_ADR;
        end else if (select_in) begin
          adr_nx = 1'b0; sel_nx = 1'b0; hold_nx = 1'b0;
          result_nx = RES_NO_DEVICE; state_nx = FINISH;
        end else if (status_in) begin
          status_nx = bus_in; perr_nx = perr | bad_par;
          adr_nx = 1'b0; sel_nx = 1'b0; hold_nx = 1'b0;
          result_nx = RES_SHORT_BUSY; state_nx = FINISH;
        end
      end
      DROP_ADR: if (address_in) begin
        perr_nx = perr | bad_par;
        if (bus_in != addr_q) begin
          result_nx = RES_BAD_ADDR; state_nx = FINISH;
        end else begin
          bus_nx = cmd_q; cmdt_nx = 1'b1; state_nx = CMD;
        end
      end
      CMD: if (!address_in) state_nx = CMD_DROP;
      CMD_DROP: begin
        cmdt_nx = 1'b0; state_nx = ISTAT;
      end
      ISTAT, FSTAT: if (status_in) begin
        status_nx = bus_in; perr_nx = perr | bad_par;
        bus_nx = 8'h00; svc_nx = 1'b1; fin_nx = (state == FSTAT);
        state_nx = SVC_ACK;
      end
      SVC_ACK: if (!status_in) begin
        svc_nx   = 1'b0;
        state_nx = (fin || status_ends(status)) ? FINISH : DATA;
      end
      // A status tag during data transfer is a short transfer and wins over service.
      DATA: begin
        if (status_in) begin
          state_nx = FSTAT;
        end else if (service_in && residual != 16'd0) begin
          if (write_op) begin
            bus_nx = tx_data; txr_nx = 1'b1;
          end else begin
            bus_nx = 8'h00; rxd_nx = bus_in; rxv_nx = 1'b1; perr_nx = perr | bad_par;
          end
          svc_nx = 1'b1; resid_nx = residual - 16'd1; state_nx = DATA_ACK;
        end else if (service_in) begin
          bus_nx = 8'h00; cmdt_nx = 1'b1; state_nx = STOP;
        end
      end
      DATA_ACK: if (!service_in) begin
        svc_nx = 1'b0; state_nx = DATA;
      end
      STOP: if (!service_in) begin
        cmdt_nx = 1'b0; state_nx = FSTAT;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (state != IDLE && state != FINISH && expired) begin
      adr_nx = 1'b0; cmdt_nx = 1'b0; svc_nx = 1'b0; hold_nx = 1'b0; sel_nx = 1'b0;
      result_nx = RES_TIMEOUT; state_nx = FINISH;
    end
    // A parity error anywhere in the operation overrides every other code.
    if (perr_nx) result_nx = RES_PARITY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;      phase <= 1'b0;      fin <= 1'b0;       write_op <= 1'b0;
      perr <= 1'b0;       address_out <= 1'b0; command_out <= 1'b0; service_out <= 1'b0;
      hold_out <= 1'b0;   select_out <= 1'b0; tx_ready <= 1'b0;  rx_valid <= 1'b0;
      status <= 8'h00;    result <= RES_OK;   residual <= 16'd0;
    end else begin
      state <= state_nx;  phase <= phase_nx;  fin <= fin_nx;     write_op <= write_nx;
      perr <= perr_nx;    address_out <= adr_nx; command_out <= cmdt_nx; service_out <= svc_nx;
      hold_out <= hold_nx; select_out <= sel_nx; tx_ready <= txr_nx; rx_valid <= rxv_nx;
      status <= status_nx; result <= result_nx; residual <= resid_nx;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_nx;
    cmd_q   <= cmd_nx;
    bus_reg <= bus_nx;
    rx_data <= rxd_nx;
  end

endmodule

// File: doc/channel_sel.md
CHANNEL_SEL -- requirements
Module: channel_sel

Interface
REQ-001 Parameter TIMEOUT, 1024, cycles allowed in any wait state before abort.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins an operation when busy=0; ignored when busy=1.
REQ-005 dev_addr / command  input  8 each  device address and command byte, sampled on start.
REQ-006 byte_count  input  16  bytes to transfer, sampled on start.
REQ-007 tx_data  input  8  next write byte; tx_ready  output  1  one-cycle pulse when tx_data is consumed.
REQ-008 rx_data  output  8  read byte; rx_valid  output  1  one-cycle qualifier.
REQ-009 busy / done  output  1 each  operation in progress / one-cycle completion pulse.
REQ-010 status  output  8  last status byte accepted; result  output  3  completion code; residual  output  16  bytes not transferred.
REQ-011 bus_out, bus_out_parity  output  8,1  channel bus out, odd parity; bus_in, bus_in_parity  input  8,1.
REQ-012 operational_out, hold_out, select_out, address_out, command_out, service_out, suppress_out  output  1 each  outbound tags.
REQ-013 operational_in, select_in, address_in, status_in, service_in, request_in  input  1 each  inbound tags; request_in unused.

Function
REQ-014 bus_out_parity SHALL equal ~^bus_out every cycle; bus_out SHALL be 0 whenever address_out, command_out and service_out are all low.
REQ-015 operational_out SHALL be 1 whenever reset is low; suppress_out SHALL be 0 always.
REQ-016 States: IDLE, SEL, DROP_ADR, CMD, CMD_DROP, ISTAT, DATA, DATA_ACK, STOP, FSTAT, SVC_ACK, FINISH.
REQ-017 IDLE: on start, latch inputs, busy=1, go SEL next cycle.
REQ-018 SEL: drive bus_out=dev_addr, address_out=1; one cycle later raise hold_out and select_out; then operational_in -> DROP_ADR; select_in -> drop tags, result=NO_DEVICE(1), FINISH; status_in without operational_in -> capture status, result=SHORT_BUSY(2), drop select_out/hold_out, FINISH.
REQ-019 DROP_ADR: drop address_out, select_out, hold_out; on address_in compare bus_in to dev_addr; mismatch -> result=BAD_ADDR(3), FINISH; match -> CMD.
REQ-020 CMD: bus_out=command, command_out=1 until address_in falls, then CMD_DROP; CMD_DROP drops command_out and goes to ISTAT.
REQ-021 ISTAT/FSTAT: on status_in capture status=bus_in, raise service_out, hold until status_in falls (SVC_ACK), then drop service_out.
REQ-022 After initial status: any of BUSY(bit4), UC(bit1), or CE+DE(bits 3,2 both set) -> result=OK(0), FINISH; else DATA. After final status -> FINISH, result=OK unless already set.
REQ-023 DATA: on service_in with residual>0: write -> bus_out=tx_data, tx_ready pulse, service_out=1; read -> rx_data=bus_in, rx_valid pulse, service_out=1; residual decrements by 1; go DATA_ACK, which drops service_out once service_in falls, then DATA.
REQ-024 DATA with residual=0 and service_in: raise command_out (stop) until service_in falls, drop it, go FSTAT.
REQ-025 status_in in DATA: go FSTAT directly (short transfer); residual retains remaining count.
REQ-026 Parity error on any captured bus_in byte sets result=PARITY(5) sticky; operation continues.
REQ-027 Counter reloads on every state change; reaching TIMEOUT in any state except IDLE/FINISH -> drop all tags except operational_out, result=TIMEOUT(4), FINISH.
REQ-028 FINISH: done=1 for one cycle, busy=0, return IDLE; start arriving simultaneously is ignored.
REQ-029 Write vs read decided by command bit0/bit1: 8'h01 write, 8'h02 read; other commands never enter DATA unless status requires, then treated as read.

Reset
REQ-030 Reset SHALL asynchronously force IDLE, all tags 0 including operational_out, bus_out=0, busy=done=tx_ready=rx_valid=0, status=0, result=0, residual=0.
REQ-031 Reset asserted mid-operation SHALL drop every tag within the same cycle; no done pulse.

Structure
REQ-032 Shared package channel_pkg: result codes, status bit positions (BUSY, CE, DE, UC), command codes WRITE/READ/NOP, state enumeration.
REQ-033 One sub-module chan_timer: loadable TIMEOUT down-counter with expiry flag.

Verification
REQ-034 Partner CU at 8'hff, NOP 8'h03: status 8'h0C, result 0, residual 0, one done pulse.
REQ-035 READ 8'h02, byte_count 4, CU limit 4: rx bytes 01,02,03,04, final status 8'h0C, residual 0.
REQ-036 WRITE 8'h01, byte_count 2, CU limit 8: two tx_ready pulses, stop via command_out, status 8'h0C, residual 0.
REQ-037 dev_addr 8'h10 with no responder returning select_in: result 1 within 10 cycles; CU short-busy: status 8'h10, result 2.
REQ-038 CU silent after address_in: result 4 after TIMEOUT cycles; reset mid-DATA drops all tags same cycle.
